// File: rtl/vrased_reset_ctrl.sv
// VRASED reset controller: turns monitor violations into an MCU reset held for HOLD_CYCLES,
// then waits for the core to reach RESET_HANDLER. Optional episode counter: VRASED_VIOL_COUNT_EN.
module vrased_reset_ctrl #(
  parameter logic [7:0]  HOLD_CYCLES   = 8'd16,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_pc,
  input  logic [3:0]  i_viol,
  output logic        o_sys_reset,
  output logic [3:0]  o_cause,
  output logic [7:0]  o_viol_count,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HOLD    = 2'b01,
    ST_WAIT_RH = 2'b10,
    ST_BAD     = 2'b11
  } state_t;

  localparam logic [7:0] HOLD_RELOAD = HOLD_CYCLES - 8'd1;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_hcnt;
  logic [7:0] w_next_hcnt;
  logic [3:0] r_cause;
  logic [3:0] w_next_cause;
  logic       w_any_viol;

  assign w_any_viol = |i_viol;

  // Reset must reach the MCU in the same cycle the violation appears, not one clock later.
  assign o_sys_reset = (r_state == ST_HOLD) | w_any_viol;

  always_comb begin
    w_next_state = r_state;
    w_next_hcnt  = r_hcnt;
    w_next_cause = r_cause;
    case (r_state)
      ST_RUN: begin
        if (w_any_viol) begin
          w_next_state = ST_HOLD;
          w_next_hcnt  = HOLD_RELOAD;
          w_next_cause = i_viol;
        end
      end
      ST_HOLD: begin
        if (w_any_viol) begin
          w_next_hcnt  = HOLD_RELOAD;
          w_next_cause = r_cause | i_viol;
        end else if (r_hcnt == 8'd0) begin
          w_next_state = ST_WAIT_RH;
        end else begin
          w_next_hcnt = r_hcnt - 8'd1;
        end
      end
      ST_WAIT_RH: begin
        // A violation wins over reaching the handler.
        if (w_any_viol) begin
          w_next_state = ST_HOLD;
          w_next_hcnt  = HOLD_RELOAD;
          w_next_cause = r_cause | i_viol;
        end else if (i_pc == RESET_HANDLER) begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_HOLD;
        w_next_hcnt  = HOLD_RELOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HOLD;
      r_hcnt  <= HOLD_RELOAD;
      r_cause <= 4'h0;
    end else begin
      r_state <= w_next_state;
      r_hcnt  <= w_next_hcnt;
      r_cause <= w_next_cause;
    end
  end

`ifdef VRASED_VIOL_COUNT_EN
  logic [7:0] r_viol_count;
  logic       w_count_inc;

  // Only a fresh episode out of RUN counts; re-triggers extend the same episode.
  assign w_count_inc = (r_state == ST_RUN) && w_any_viol;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_viol_count <= 8'h00;
    end else if (w_count_inc && (r_viol_count != 8'hFF)) begin
      r_viol_count <= r_viol_count + 8'd1;
    end
  end

  assign o_viol_count = r_viol_count;
`else
  assign o_viol_count = 8'h00;
`endif

  assign o_cause = r_cause;
  assign o_state = r_state;

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Table-driven bench for vrased_reset_ctrl (default parameters), plus a saturation sequence.
module tb_vrased_reset_ctrl;

  localparam logic [1:0] RUN  = 2'b00;
  localparam logic [1:0] HOLD = 2'b01;
  localparam logic [1:0] WAIT = 2'b10;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic [3:0]  viol;
  logic        sysReset;
  logic [3:0]  cause;
  logic [7:0]  violCount;
  logic [1:0]  state;

  int vectorsApplied;
  int miscompares;

  typedef struct {
    string       name;
    int          reps;
    logic        rst;
    logic [3:0]  viol;
    logic [15:0] pc;
    logic        expSys;
    logic [1:0]  expState;
    logic [3:0]  expCause;
    logic [7:0]  expCount;
  } vec_t;

  vec_t vecs[$];

  vrased_reset_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pc        (pc),
    .i_viol      (viol),
    .o_sys_reset (sysReset),
    .o_cause     (cause),
    .o_viol_count(violCount),
    .o_state     (state)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected episode count: saturating when the counter is built, constant zero otherwise
  function automatic logic [7:0] expCnt(input int n);
    logic [7:0] c;
    c = (n > 255) ? 8'hFF : 8'(n);
`ifdef VRASED_VIOL_COUNT_EN
    return c;
`else
    return c & 8'h00;
`endif
  endfunction

  function automatic void addVec(input string name, input int reps, input logic r,
                                 input logic [3:0] v, input logic [15:0] p, input logic es,
                                 input logic [1:0] est, input logic [3:0] ec, input logic [7:0] en);
    vec_t t;
    t.name = name; t.reps = reps; t.rst = r; t.viol = v; t.pc = p;
    t.expSys = es; t.expState = est; t.expCause = ec; t.expCount = en;
    vecs.push_back(t);
  endfunction

  // Drive inputs on the falling edge and let combinational outputs settle
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [15:0] p);
    @(negedge clk);
    rst  = r;
    viol = v;
    pc   = p;
    #1;
  endtask

  // Compare all outputs against the expected values; one FAIL line per bad field
  task automatic checkOutput(input string name, input logic es, input logic [1:0] est,
                             input logic [3:0] ec, input logic [7:0] en);
    vectorsApplied++;
    if (sysReset !== es) begin
      miscompares++;
      $display("[TB] FAIL %s sys_reset: got %b expected %b", name, sysReset, es);
    end
    if (state !== est) begin
      miscompares++;
      $display("[TB] FAIL %s state: got %b expected %b", name, state, est);
    end
    if (cause !== ec) begin
      miscompares++;
      $display("[TB] FAIL %s cause: got %h expected %h", name, cause, ec);
    end
    if (violCount !== en) begin
      miscompares++;
      $display("[TB] FAIL %s viol_count: got %h expected %h", name, violCount, en);
    end
  endtask

  // One RUN->HOLD->WAIT_RH->RUN episode; returns 0 if WAIT_RH never arrived
  task automatic runEpisode(output bit ok);
    int n;
    ok = 1'b0;
    applyStimulus(1'b0, 4'b0001, 16'h0100);
    n = 0;
    while (n < 40) begin
      applyStimulus(1'b0, 4'b0000, 16'h0100);
      if (state == WAIT) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    applyStimulus(1'b0, 4'b0000, 16'h0000);
    applyStimulus(1'b0, 4'b0000, 16'h0100);
  endtask

  initial begin
    bit ok;
    bit allOk;
    vectorsApplied = 0;
    miscompares    = 0;
    rst  = 1'b1;
    viol = 4'h0;
    pc   = 16'h1234;
    repeat (2) @(posedge clk);

    addVec("rstHeld",      1,  1'b1, 4'h0, 16'h1234, 1'b1, HOLD, 4'h0, expCnt(0));
    addVec("postRstHold",  16, 1'b0, 4'h0, 16'h1234, 1'b1, HOLD, 4'h0, expCnt(0));
    addVec("waitRh",       2,  1'b0, 4'h0, 16'h1234, 1'b0, WAIT, 4'h0, expCnt(0));
    addVec("pcAtHandler",  1,  1'b0, 4'h0, 16'h0000, 1'b0, WAIT, 4'h0, expCnt(0));
    addVec("run",          2,  1'b0, 4'h0, 16'h0100, 1'b0, RUN,  4'h0, expCnt(0));
    addVec("dmaPulse",     1,  1'b0, 4'h1, 16'h0100, 1'b1, RUN,  4'h0, expCnt(0));
    addVec("dmaHold",      16, 1'b0, 4'h0, 16'h0100, 1'b1, HOLD, 4'h1, expCnt(1));
    addVec("dmaWait",      1,  1'b0, 4'h0, 16'h0100, 1'b0, WAIT, 4'h1, expCnt(1));
    addVec("keyAtHandler", 1,  1'b0, 4'h2, 16'h0000, 1'b1, WAIT, 4'h1, expCnt(1));
    addVec("keyHold",      16, 1'b0, 4'h0, 16'h0000, 1'b1, HOLD, 4'h3, expCnt(1));
    addVec("keyWaitExit",  1,  1'b0, 4'h0, 16'h0000, 1'b0, WAIT, 4'h3, expCnt(1));
    addVec("causeSticky",  1,  1'b0, 4'h0, 16'h0100, 1'b0, RUN,  4'h3, expCnt(1));
    addVec("dmaAgain",     1,  1'b0, 4'h1, 16'h0100, 1'b1, RUN,  4'h3, expCnt(1));
    addVec("holdToThree",  12, 1'b0, 4'h0, 16'h0100, 1'b1, HOLD, 4'h1, expCnt(2));
    addVec("atomRetrig",   1,  1'b0, 4'h4, 16'h0100, 1'b1, HOLD, 4'h1, expCnt(2));
    addVec("retrigHold",   16, 1'b0, 4'h0, 16'h0100, 1'b1, HOLD, 4'h5, expCnt(2));
    addVec("retrigWait",   1,  1'b0, 4'h0, 16'h0100, 1'b0, WAIT, 4'h5, expCnt(2));
    addVec("backToRun",    1,  1'b0, 4'h0, 16'h0000, 1'b0, WAIT, 4'h5, expCnt(2));
    addVec("spareViol",    1,  1'b0, 4'h8, 16'h0000, 1'b1, RUN,  4'h5, expCnt(2));
    addVec("spareHold",    3,  1'b0, 4'h0, 16'h0100, 1'b1, HOLD, 4'h8, expCnt(3));
    addVec("rstMidRetrig", 1,  1'b1, 4'h2, 16'h0100, 1'b1, HOLD, 4'h8, expCnt(3));
    addVec("rstApplied",   1,  1'b1, 4'h0, 16'h0100, 1'b1, HOLD, 4'h0, expCnt(0));
    addVec("rstRelease",   16, 1'b0, 4'h0, 16'h0100, 1'b1, HOLD, 4'h0, expCnt(0));
    addVec("finalWait",    1,  1'b0, 4'h0, 16'h0000, 1'b0, WAIT, 4'h0, expCnt(0));
    addVec("finalRun",     1,  1'b0, 4'h0, 16'h0100, 1'b0, RUN,  4'h0, expCnt(0));

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        applyStimulus(vecs[i].rst, vecs[i].viol, vecs[i].pc);
        checkOutput(vecs[i].name, vecs[i].expSys, vecs[i].expState,
                    vecs[i].expCause, vecs[i].expCount);
      end
    end

    // 300 fresh episodes: the counter must pin at 8'hFF
    allOk = 1'b1;
    for (int e = 0; e < 300; e++) begin
      runEpisode(ok);
      if (!ok) allOk = 1'b0;
    end
    vectorsApplied++;
    if (!allOk) begin
      miscompares++;
      $display("[TB] FAIL episodeTimeout: got no WAIT_RH within 40 cycles, expected WAIT_RH");
    end
    checkOutput("saturated", 1'b0, RUN, 4'h1, expCnt(300));

    applyStimulus(1'b1, 4'h0, 16'h0100);
    applyStimulus(1'b1, 4'h0, 16'h0100);
    checkOutput("rstClearsCount", 1'b1, HOLD, 4'h0, expCnt(0));
    applyStimulus(1'b0, 4'h0, 16'h0100);
    checkOutput("firstAfterRst", 1'b1, HOLD, 4'h0, expCnt(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/vrased_reset_ctrl.md
VRASED_RESET_CTRL -- requirements
Module: vrased_reset_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 8'd16, number of cycles sys_reset is held after the last violation; legal range 1..255.
REQ-002 Parameter RESET_HANDLER, default 16'h0000, PC value at which the core is considered restarted.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pc  input  16  current program counter from the core.
REQ-006 viol  input  4  per-monitor violation requests: bit0 DMA, bit1 key access, bit2 atomicity, bit3 spare; active-high, level.
REQ-007 sys_reset  output  1  reset request to the MCU, active-high.
REQ-008 cause  output  4  sticky record of the viol bits that caused the most recent reset episode.
REQ-009 viol_count  output  8  saturating count of reset episodes.
REQ-010 state_o  output  2  current FSM state: RUN=2'b00, HOLD=2'b01, WAIT_RH=2'b10; 2'b11 unused.

Function
REQ-011 FSM SHALL have states RUN, HOLD and WAIT_RH, plus an 8-bit hold counter hcnt; any_viol = |viol.
REQ-012 sys_reset SHALL equal (state==HOLD) | any_viol, combinationally, so a violation asserts reset in the same cycle it is presented.
REQ-013 RUN: any_viol -> HOLD, hcnt <= HOLD_CYCLES-1, cause <= viol, viol_count += 1 (saturating at 8'hFF); otherwise stay in RUN.
REQ-014 HOLD: any_viol -> stay in HOLD, hcnt <= HOLD_CYCLES-1, cause <= cause|viol; otherwise, if hcnt==0 -> WAIT_RH, else hcnt <= hcnt-1.
REQ-015 HOLD duration SHALL therefore be exactly HOLD_CYCLES cycles after the last cycle in which any_viol was high.
REQ-016 WAIT_RH: any_viol -> HOLD, hcnt <= HOLD_CYCLES-1, cause <= cause|viol, viol_count unchanged; else if pc==RESET_HANDLER -> RUN; else stay.
REQ-017 Simultaneous violation and pc==RESET_HANDLER in WAIT_RH SHALL take the HOLD transition.
REQ-018 viol_count SHALL increment only on a RUN->HOLD transition; re-triggers in HOLD or WAIT_RH do not count.
REQ-019 cause SHALL remain unchanged in RUN so software can read it after restart.
REQ-020 Encoding 2'b11 SHALL recover to HOLD on the next clock with hcnt <= HOLD_CYCLES-1.

Reset
REQ-021 On rising clk with rst=1: state <= HOLD, hcnt <= HOLD_CYCLES-1, cause <= 4'h0, viol_count <= 8'h00.
REQ-022 While rst=1 and on the first cycle after it is released, sys_reset SHALL be 1, because the block comes out of reset in HOLD.
REQ-023 rst SHALL override every in-flight transition, including a mid-HOLD re-trigger and saturation.

Configuration
REQ-024 Macro VRASED_VIOL_COUNT_EN: when defined, viol_count SHALL be implemented per REQ-013/018/021.
REQ-025 When VRASED_VIOL_COUNT_EN is undefined, viol_count SHALL be tied to 8'h00, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-026 Release rst with pc=16'h1234 and viol=0 -> sys_reset=1 for 16 cycles, state goes to WAIT_RH, sys_reset=0; drive pc=16'h0000 -> RUN next clock.
REQ-027 In RUN, pulse viol=4'b0001 for 1 cycle -> sys_reset=1 in that cycle plus 16 more; cause=4'h1; viol_count 0->1.
REQ-028 In HOLD with hcnt=3, drive viol=4'b0100 -> hcnt reloads to 15, cause=4'h5, viol_count unchanged, HOLD lasts 16 more cycles.
REQ-029 In WAIT_RH, drive viol=4'b0010 together with pc=16'h0000 -> HOLD, sys_reset=1, cause |= 4'h2, viol_count unchanged.
REQ-030 With VRASED_VIOL_COUNT_EN defined, run 300 RUN->HOLD episodes -> viol_count=8'hFF; assert rst -> 8'h00; rebuild without the macro -> viol_count is always 8'h00.
